// File: rtl/keypad_pkg.sv
// Shared types, tables and helpers for the 4x4 keypad scanner.
//
// Contents:
//   state_e      - scanner FSM states: SCAN, DEBOUNCE, HELD
//   ROW_DRIVE    - row index -> active-low row drive pattern
//   KEY_MAP      - [row][col] -> 4-bit key code
//   col_index()  - decodes an active-low column pattern into {valid, j}
//   key_code_of()- table lookup wrapper for KEY_MAP
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    // Element i drives row bit (3-i) low: 0->0111, 1->1011, 2->1101, 3->1110.
    localparam logic [3:0][3:0] ROW_DRIVE = {4'b1110, 4'b1101, 4'b1011, 4'b0111};

    // KEY_MAP[i][j]; each 16-bit row slice lists columns 3..0 from MSB to LSB.
    //   row0: F E D C   row1: B 3 6 9   row2: A 2 5 8   row3: 0 1 4 7
    localparam logic [3:0][3:0][3:0] KEY_MAP = {
        16'h7410,   // row3
        16'h852A,   // row2
        16'h963B,   // row1
        16'hCDEF    // row0
    };

    // Returns {valid, j}. Only a pattern with exactly one low bit is a key;
    // idle (1111) and multi-key patterns report valid=0.
    function automatic logic [2:0] col_index(input logic [3:0] col);
        logic [2:0] res;
        case (col)
            4'b0111: res = 3'b100;
            4'b1011: res = 3'b101;
            4'b1101: res = 3'b110;
            4'b1110: res = 3'b111;
            default: res = 3'b000;
        endcase
        return res;
    endfunction

    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        return KEY_MAP[row][col];
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
//
// Parameters:
//   WIDTH     - number of independent bits synchronized
//   RESET_VAL - value both stages take under reset
// Ports:
//   clk - destination clock
//   rst - synchronous active-high reset
//   d   - asynchronous input
//   q   - synchronized output (two clk of latency)
module sync_2ff #(
    parameter int unsigned      WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scan_debounce.sv
// 4x4 keypad row scanner with press/release debouncing.
//
// Drives one row low at a time, samples the synchronized columns once per row
// dwell, and after DEBOUNCE_SCANS matching samples emits a single-cycle
// key_valid with the key code. The row stays frozen while a key is being
// debounced or held, so one physical press yields exactly one event.
//
// Parameters:
//   SCAN_DIV       - clk cycles per row dwell; columns sampled on the last one (>= 4)
//   DEBOUNCE_SCANS - consecutive matching samples to accept a press or release (>= 2)
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   keypad_row - active-low row drive, exactly one bit low
//   keypad_col - active-low column sense, asynchronous
//   key_valid  - one-cycle pulse on an accepted press
//   key_code   - code of the last accepted key, held between events
//   key_held   - high from key_valid until the release is accepted
module keypad_scan_debounce
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 25000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] keypad_row,
    input  logic [3:0] keypad_col,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_held
);

    localparam int unsigned DWELL_W = $clog2(SCAN_DIV);
    localparam int unsigned DB_W    = $clog2(DEBOUNCE_SCANS + 1);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    // Compare against N-1 before incrementing so reaching N is acted on in
    // the same sample cycle.
    localparam logic [DB_W-1:0]    DB_LAST    = DB_W'(DEBOUNCE_SCANS - 1);

    logic [3:0] col_s;

    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (keypad_col),
        .q   (col_s)
    );

    state_e             state_q, state_d;
    logic [1:0]         row_q, row_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DB_W-1:0]    match_q, match_d;
    logic [DB_W-1:0]    rel_q, rel_d;
    logic [3:0]         pat_q, pat_d;
    logic [1:0]         col_j_q, col_j_d;
    logic               valid_q, valid_d;
    logic [3:0]         code_q, code_d;
    logic               held_q, held_d;

    logic       sample;
    logic [2:0] col_dec;
    logic       col_ok;
    logic [1:0] col_j;

    assign sample  = (dwell_q == DWELL_LAST);
    assign col_dec = col_index(col_s);
    assign col_ok  = col_dec[2];
    assign col_j   = col_dec[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            row_q   <= 2'd0;
            dwell_q <= '0;
            match_q <= '0;
            rel_q   <= '0;
            pat_q   <= 4'hF;
            col_j_q <= 2'd0;
            valid_q <= 1'b0;
            code_q  <= 4'h0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            match_q <= match_d;
            rel_q   <= rel_d;
            pat_q   <= pat_d;
            col_j_q <= col_j_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        match_d = match_q;
        rel_d   = rel_q;
        pat_d   = pat_q;
        col_j_d = col_j_q;
        valid_d = 1'b0;
        code_d  = code_q;
        held_d  = held_q;
        dwell_d = sample ? '0 : dwell_q + DWELL_W'(1);

        case (state_q)
            SCAN: begin
                if (sample) begin
                    if (col_ok) begin
                        pat_d   = col_s;
                        col_j_d = col_j;
                        match_d = DB_W'(1);
                        state_d = DEBOUNCE;
                    end else begin
                        row_d = row_q + 2'd1;
                    end
                end
            end

            DEBOUNCE: begin
                if (sample) begin
                    if (col_s == pat_q) begin
                        if (match_q == DB_LAST) begin
                            valid_d = 1'b1;
                            code_d  = key_code_of(row_q, col_j_q);
                            held_d  = 1'b1;
                            match_d = '0;
                            rel_d   = '0;
                            state_d = HELD;
                        end else begin
                            match_d = match_q + DB_W'(1);
                        end
                    end else begin
                        // Bounce: drop the candidate and move on without an event.
                        match_d = '0;
                        row_d   = row_q + 2'd1;
                        state_d = SCAN;
                    end
                end
            end

            HELD: begin
                if (sample) begin
                    if (col_s == 4'hF) begin
                        if (rel_q == DB_LAST) begin
                            rel_d   = '0;
                            held_d  = 1'b0;
                            row_d   = row_q + 2'd1;
                            state_d = SCAN;
                        end else begin
                            rel_d = rel_q + DB_W'(1);
                        end
                    end else begin
                        // Any non-idle pattern, including another key in this row,
                        // restarts the release qualification.
                        rel_d = '0;
                    end
                end
            end

            default: state_d = SCAN;
        endcase
    end

    assign keypad_row = ROW_DRIVE[row_q];
    assign key_valid  = valid_q;
    assign key_code   = code_q;
    assign key_held   = held_q;

endmodule
